micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Parametrised microprogram sequencer for the Relatively Simple CPU family: holds the micro-PC,
//  reads a microcode ROM, drives the control-field vector to the datapath, and computes the next
//  micro-address from branch type, opcode map, condition flags and memory-ready stall.
//  Sits between the instruction register/flag logic and the datapath control decoder.
// PARAMETERS
//  OP_W         4                         opcode width presented for MAP dispatch
//  AW           6                         micro-address width (ROM depth 2**AW)
//  CTRL_W       25                        control-field width driven to datapath
//  NFLAGS       4                         number of condition flags (CF_W = $clog2(NFLAGS))
//  MAP_SHIFT    2                         MAP target = {opcode, MAP_SHIFT'b0}, truncated to AW
//  RESET_ADDR   0                         micro-address entered on reset and on data-fetch MAP
//  ILLEGAL_ADDR 63                        target when MAP opcode exceeds 2**(AW-MAP_SHIFT)-1
//  STACK_DEPTH  4                         micro-call stack entries (MICRO_CALL_EN only)
//  UCODE_FILE   "microcoded_memory.txt"   $readmemh image; word UW = 3+CF_W+1+AW+CTRL_W bits
// PORTS
//  clk       in   1       rising-edge clock
//  reset     in   1       synchronous, active-high reset
//  opcode    in   OP_W    instruction opcode for MAP
//  op_valid  in   1       1: opcode is an instruction; 0: data word, MAP goes to RESET_ADDR
//  flags     in   NFLAGS  condition flags (e.g. Z, N) sampled for CBR
//  mem_ready in   1       memory handshake; WAIT words hold while 0
//  ctrl      out  CTRL_W  control field of the currently executing microword
//  upc       out  AW      current micro-address
//  halted    out  1       high after HALT executes, until reset
//  err       out  1       one-cycle pulse: illegal MAP, stack overflow/underflow
// BEHAVIOUR
//  - Microword fields MSB->LSB: BT[2:0], COND[CF_W-1:0], POL, ADDR[AW-1:0], CTRL[CTRL_W-1:0].
//  - ROM read is asynchronous from upc; ctrl = CTRL field, forced to 0 while reset or halted.
//  - One microword per clk; upc <= next address on every rising edge (latency 1 cycle).
//  - reset=1 at a clock edge: upc<=RESET_ADDR, halted<=0, err<=0, stack pointer<=0; wins over all
//    other events, including mid-WAIT and mid-subroutine. ctrl=0 during the reset cycle.
//  - BT encodings / next address:
//      0 NEXT : upc+1 (wraps 2**AW-1 -> 0)
//      1 JUMP : ADDR
//      2 MAP  : op_valid=0 -> RESET_ADDR; opcode legal -> {opcode,MAP_SHIFT'b0}; else ILLEGAL_ADDR + err
//      3 CBR  : flags[COND]==POL -> ADDR, else upc+1
//      4 WAIT : mem_ready=1 -> ADDR; mem_ready=0 -> hold upc, ctrl stays asserted
//      5 CALL : push upc+1, go ADDR
//      6 RET  : pop -> target
//      7 HALT : hold upc, halted<=1; leaves only via reset
//  - COND >= NFLAGS selects constant 0.
//  - err is registered: asserted the cycle after the offending word, cleared next cycle.
// CONFIGURATION
//  - Macro MICRO_CALL_EN defined: STACK_DEPTH-entry LIFO; CALL on full stack -> no push, jump
//    still taken, err; RET on empty -> RESET_ADDR, err. CALL and RET never coincide (one word/cycle).
//  - Macro undefined: no stack logic; CALL behaves as JUMP, RET behaves as NEXT, both pulse err.
// STRUCTURE
//  - Package useq_pkg: BT enum (BT_NEXT..BT_HALT), field-offset localparams computed from
//    CF_W/AW/CTRL_W, ROM word width function.
//  - Sub-module useq_stack (LIFO, push/pop/full/empty, sync reset), instantiated only under
//    MICRO_CALL_EN. ROM array and next-address mux live in micro_sequencer.
// TESTING
//  - reset 3 cycles, ROM[0]=NEXT ctrl=0x1 -> ctrl=0 during reset; upc 0 then 1 after release.
//  - MAP, op_valid=1, opcode=4'h3 -> upc=0x0C next cycle; op_valid=0 -> upc=RESET_ADDR.
//  - CBR COND=0 POL=1 ADDR=0x20: flags=4'b0001 -> upc=0x20; flags=4'b0000 -> upc+1.
//  - WAIT ADDR=0x05, mem_ready low 3 cycles -> upc and ctrl held 3 cycles, upc=0x05 cycle after ready.
//  - MICRO_CALL_EN: 5 nested CALLs at depth 4 -> err on 5th; 5 RETs -> 4 correct returns, 5th to 0 + err.
//  - HALT at 0x3E then 10 cycles -> halted=1, ctrl=0, upc=0x3E; reset mid-HALT -> upc=0, halted=0.

Source files
------------

// File: rtl/useq_pkg.sv
// Shared definitions for the microprogram sequencer: branch-type encoding,
// microword field layout helpers and the ROM word width.
package useq_pkg;

    typedef enum logic [2:0] {
        BT_NEXT = 3'd0,
        BT_JUMP = 3'd1,
        BT_MAP  = 3'd2,
        BT_CBR  = 3'd3,
        BT_WAIT = 3'd4,
        BT_CALL = 3'd5,
        BT_RET  = 3'd6,
        BT_HALT = 3'd7
    } bt_e;

    localparam int unsigned BT_W  = 3;
    localparam int unsigned POL_W = 1;

    // Condition-select width; a single flag still needs one select bit.
    function automatic int unsigned cf_width(input int unsigned nflags);
        return (nflags > 1) ? $clog2(nflags) : 1;
    endfunction

    // Microword layout, MSB->LSB: BT, COND, POL, ADDR, CTRL.
    function automatic int unsigned uword_width(input int unsigned cf_w,
                                                input int unsigned aw,
                                                input int unsigned ctrl_w);
        return BT_W + cf_w + POL_W + aw + ctrl_w;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned ctrl_w);
        return ctrl_w;
    endfunction

    function automatic int unsigned pol_lsb(input int unsigned aw, input int unsigned ctrl_w);
        return ctrl_w + aw;
    endfunction

    function automatic int unsigned cond_lsb(input int unsigned aw, input int unsigned ctrl_w);
        return ctrl_w + aw + POL_W;
    endfunction

    function automatic int unsigned bt_lsb(input int unsigned cf_w,
                                           input int unsigned aw,
                                           input int unsigned ctrl_w);
        return ctrl_w + aw + POL_W + cf_w;
    endfunction

endpackage

// File: rtl/useq_stack.sv
// Micro-call return-address LIFO. Push on full and pop on empty are ignored;
// the sequencer decides what those cases mean.
module useq_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 6
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SPW-1:0] sp_q, sp_d;
    logic [W-1:0]   mem_q [DEPTH];

    assign full_o  = (sp_q == SPW'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign top_o   = mem_q[IW'(sp_q - SPW'(1))];

    // Stack pointer update.
    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    // Stack pointer register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage; contents above the pointer are don't-care.
    always_ff @(posedge clk) begin
        if (push_i && !full_o && !reset_i) begin
            mem_q[IW'(sp_q)] <= data_i;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds the micro-PC, reads the microcode ROM and
// selects the next micro-address. Optional macro MICRO_CALL_EN adds a
// return-address stack for CALL/RET; without it CALL acts as JUMP and RET as
// NEXT, both flagging err. The ROM array is loaded by the surrounding
// environment from the image named by UCODE_FILE.
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int unsigned OP_W         = 4,
    parameter int unsigned AW           = 6,
    parameter int unsigned CTRL_W       = 25,
    parameter int unsigned NFLAGS       = 4,
    parameter int unsigned MAP_SHIFT    = 2,
    parameter int unsigned RESET_ADDR   = 0,
    parameter int unsigned ILLEGAL_ADDR = 63,
    parameter int unsigned STACK_DEPTH  = 4,
    parameter string       UCODE_FILE   = "microcoded_memory.txt"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   opcode,
    input  logic              op_valid,
    input  logic [NFLAGS-1:0] flags,
    input  logic              mem_ready,
    output logic [CTRL_W-1:0] ctrl,
    output logic [AW-1:0]     upc,
    output logic              halted,
    output logic              err
);

    localparam int unsigned CF_W      = cf_width(NFLAGS);
    localparam int unsigned UW        = uword_width(CF_W, AW, CTRL_W);
    localparam int unsigned ADDR_LSB  = addr_lsb(CTRL_W);
    localparam int unsigned POL_LSB   = pol_lsb(AW, CTRL_W);
    localparam int unsigned COND_LSB  = cond_lsb(AW, CTRL_W);
    localparam int unsigned BT_LSB    = bt_lsb(CF_W, AW, CTRL_W);
    localparam int unsigned FLAG_SPAN = 2 ** CF_W;
    localparam int unsigned MAP_W     = OP_W + MAP_SHIFT;
    localparam int unsigned MAP_MAX   = (1 << (AW - MAP_SHIFT)) - 1;
    localparam logic [AW-1:0] RST_A   = AW'(RESET_ADDR);
    localparam logic [AW-1:0] ILL_A   = AW'(ILLEGAL_ADDR);

    logic [UW-1:0]        rom [2 ** AW];
    logic [UW-1:0]        word_c;
    bt_e                  bt_c;
    logic [CF_W-1:0]      cond_c;
    logic                 pol_c;
    logic [AW-1:0]        addr_c;
    logic [CTRL_W-1:0]    ctrl_f_c;
    logic [FLAG_SPAN-1:0] flags_ext_c;
    logic                 flag_sel_c;
    logic [MAP_W-1:0]     map_full_c;
    logic                 map_legal_c;
    logic [AW-1:0]        upc_inc_c;

    logic [AW-1:0] upc_q, upc_d;
    logic          halted_q, halted_d;
    logic          err_q, err_d;

    // Field decode of the microword at the current micro-PC.
    assign word_c   = rom[upc_q];
    assign bt_c     = bt_e'(word_c[BT_LSB +: BT_W]);
    assign cond_c   = word_c[COND_LSB +: CF_W];
    assign pol_c    = word_c[POL_LSB];
    assign addr_c   = word_c[ADDR_LSB +: AW];
    assign ctrl_f_c = word_c[CTRL_W-1:0];

    // Selects beyond NFLAGS land on zero-extended bits, i.e. constant 0.
    assign flags_ext_c = FLAG_SPAN'(flags);
    assign flag_sel_c  = flags_ext_c[cond_c];

    assign map_full_c  = MAP_W'(opcode) << MAP_SHIFT;
    assign map_legal_c = (32'(opcode) <= MAP_MAX);
    assign upc_inc_c   = upc_q + AW'(1);

`ifdef MICRO_CALL_EN
    logic          stk_push_c, stk_pop_c, stk_full_c, stk_empty_c;
    logic [AW-1:0] stk_top_c;

    useq_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (AW)
    ) u_stack (
        .clk     (clk),
        .reset_i (reset),
        .push_i  (stk_push_c),
        .pop_i   (stk_pop_c),
        .data_i  (upc_inc_c),
        .top_o   (stk_top_c),
        .full_o  (stk_full_c),
        .empty_o (stk_empty_c)
    );
`endif

    // Next micro-address, halt and error selection.
    always_comb begin
        upc_d    = upc_inc_c;
        halted_d = halted_q;
        err_d    = 1'b0;
`ifdef MICRO_CALL_EN
        stk_push_c = 1'b0;
        stk_pop_c  = 1'b0;
`endif
        if (halted_q) begin
            upc_d = upc_q;
        end else begin
            case (bt_c)
                BT_NEXT: upc_d = upc_inc_c;
                BT_JUMP: upc_d = addr_c;
                BT_MAP: begin
                    if (!op_valid) begin
                        upc_d = RST_A;
                    end else if (map_legal_c) begin
                        upc_d = AW'(map_full_c);
                    end else begin
                        upc_d = ILL_A;
                        err_d = 1'b1;
                    end
                end
                BT_CBR: begin
                    if (flag_sel_c == pol_c) begin
                        upc_d = addr_c;
                    end
                end
                BT_WAIT: upc_d = mem_ready ? addr_c : upc_q;
                BT_CALL: begin
                    upc_d = addr_c;
`ifdef MICRO_CALL_EN
                    if (stk_full_c) begin
                        err_d = 1'b1;
                    end else begin
                        stk_push_c = 1'b1;
                    end
`else
                    err_d = 1'b1;
`endif
                end
                BT_RET: begin
`ifdef MICRO_CALL_EN
                    if (stk_empty_c) begin
                        upc_d = RST_A;
                        err_d = 1'b1;
                    end else begin
                        upc_d     = stk_top_c;
                        stk_pop_c = 1'b1;
                    end
`else
                    err_d = 1'b1;
`endif
                end
                BT_HALT: begin
                    upc_d    = upc_q;
                    halted_d = 1'b1;
                end
                default: upc_d = upc_inc_c;
            endcase
        end
    end

    // Sequencer state; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            upc_q    <= RST_A;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            upc_q    <= upc_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign ctrl   = (reset || halted_q) ? '0 : ctrl_f_c;
    assign upc    = upc_q;
    assign halted = halted_q;
    assign err    = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer; follows MICRO_CALL_EN for CALL/RET expectations.
module tb_micro_sequencer;

    localparam int unsigned UW = 37;

    localparam logic [2:0] NEXT = 3'd0;
    localparam logic [2:0] JUMP = 3'd1;
    localparam logic [2:0] MAP  = 3'd2;
    localparam logic [2:0] CBR  = 3'd3;
    localparam logic [2:0] WAIT = 3'd4;
    localparam logic [2:0] CALL = 3'd5;
    localparam logic [2:0] RET  = 3'd6;
    localparam logic [2:0] HALT = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode;
    logic        op_valid;
    logic [3:0]  flags;
    logic        mem_ready;
    logic [24:0] ctrl;
    logic [5:0]  upc;
    logic        halted;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [5:0] exp_upc [$];
    logic       exp_err [$];

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .op_valid  (op_valid),
        .flags     (flags),
        .mem_ready (mem_ready),
        .ctrl      (ctrl),
        .upc       (upc),
        .halted    (halted),
        .err       (err)
    );

    function automatic logic [UW-1:0] uw(input logic [2:0] bt, input logic [1:0] cond,
                                         input logic pol, input logic [5:0] addr,
                                         input logic [24:0] c);
        return {bt, cond, pol, addr, c};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) dut.rom[i] = '0;
    endtask

    initial begin
        reset = 1'b1; opcode = 4'h3; op_valid = 1'b1; flags = 4'b0000; mem_ready = 1'b1;

        // Reset, NEXT and MAP dispatch
        clear_rom();
        dut.rom[0]     = uw(NEXT, 2'd0, 1'b0, 6'h00, 25'h1);
        dut.rom[1]     = uw(NEXT, 2'd0, 1'b0, 6'h00, 25'h2);
        dut.rom[2]     = uw(MAP,  2'd0, 1'b0, 6'h00, 25'h3);
        dut.rom[6'h0C] = uw(MAP,  2'd0, 1'b0, 6'h00, 25'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_upc", 64'(upc), 64'h0);
            check("rst_ctrl", 64'(ctrl), 64'h0);
            check("rst_halted", 64'(halted), 64'h0);
            check("rst_err", 64'(err), 64'h0);
        end
        reset = 1'b0; #1;
        check("rel_ctrl", 64'(ctrl), 64'h1);
        tick(); check("next_upc", 64'(upc), 64'h1); check("next_ctrl", 64'(ctrl), 64'h2);
        tick(); check("next2_upc", 64'(upc), 64'h2);
        tick(); check("map_op3_upc", 64'(upc), 64'h0C); check("map_err", 64'(err), 64'h0);
        op_valid = 1'b0;
        tick(); check("map_data_upc", 64'(upc), 64'h00);
        op_valid = 1'b1;

        // CBR, WAIT and address wrap
        reset = 1'b1;
        clear_rom();
        dut.rom[0]     = uw(CBR,  2'd0, 1'b1, 6'h20, 25'h10);
        dut.rom[6'h20] = uw(JUMP, 2'd0, 1'b0, 6'h00, 25'h20);
        dut.rom[1]     = uw(CBR,  2'd1, 1'b0, 6'h30, 25'h11);
        dut.rom[6'h30] = uw(WAIT, 2'd0, 1'b0, 6'h05, 25'h1ABCDEF);
        dut.rom[5]     = uw(JUMP, 2'd0, 1'b0, 6'h3F, 25'h5);
        dut.rom[6'h3F] = uw(NEXT, 2'd0, 1'b0, 6'h00, 25'h3F);
        tick();
        reset = 1'b0; flags = 4'b0001;
        tick(); check("cbr_taken_upc", 64'(upc), 64'h20);
        tick(); check("jump_upc", 64'(upc), 64'h00);
        flags = 4'b0000;
        tick(); check("cbr_fall_upc", 64'(upc), 64'h01);
        flags = 4'b1101;
        tick(); check("cbr_pol0_upc", 64'(upc), 64'h30);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_hold_upc", 64'(upc), 64'h30);
            check("wait_hold_ctrl", 64'(ctrl), 64'h1ABCDEF);
        end
        mem_ready = 1'b1;
        tick(); check("wait_done_upc", 64'(upc), 64'h05);
        tick(); check("top_upc", 64'(upc), 64'h3F); check("top_ctrl", 64'(ctrl), 64'h3F);
        tick(); check("wrap_upc", 64'(upc), 64'h00);

        // Nested CALL/RET
        reset = 1'b1;
        clear_rom();
        dut.rom[0]     = uw(JUMP, 2'd0, 1'b0, 6'h10, 25'h0);
        dut.rom[6'h10] = uw(CALL, 2'd0, 1'b0, 6'h18, 25'h0);
        dut.rom[6'h18] = uw(CALL, 2'd0, 1'b0, 6'h20, 25'h0);
        dut.rom[6'h20] = uw(CALL, 2'd0, 1'b0, 6'h28, 25'h0);
        dut.rom[6'h28] = uw(CALL, 2'd0, 1'b0, 6'h30, 25'h0);
        dut.rom[6'h30] = uw(CALL, 2'd0, 1'b0, 6'h38, 25'h0);
        dut.rom[6'h38] = uw(RET,  2'd0, 1'b0, 6'h00, 25'h0);
        dut.rom[6'h29] = uw(RET,  2'd0, 1'b0, 6'h00, 25'h0);
        dut.rom[6'h21] = uw(RET,  2'd0, 1'b0, 6'h00, 25'h0);
        dut.rom[6'h19] = uw(RET,  2'd0, 1'b0, 6'h00, 25'h0);
        dut.rom[6'h11] = uw(RET,  2'd0, 1'b0, 6'h00, 25'h0);
`ifdef MICRO_CALL_EN
        exp_upc = '{6'h10, 6'h18, 6'h20, 6'h28, 6'h30, 6'h38, 6'h29, 6'h21, 6'h19, 6'h11, 6'h00, 6'h10};
        exp_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_upc = '{6'h10, 6'h18, 6'h20, 6'h28, 6'h30, 6'h38, 6'h39, 6'h3A};
        exp_err = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        tick();
        reset = 1'b0;
        for (int i = 0; i < exp_upc.size(); i++) begin
            tick();
            check("call_upc", 64'(upc), 64'(exp_upc[i]));
            check("call_err", 64'(err), 64'(exp_err[i]));
        end

        // HALT and reset out of HALT
        reset = 1'b1;
        clear_rom();
        dut.rom[0]     = uw(JUMP, 2'd0, 1'b0, 6'h3E, 25'h7);
        dut.rom[6'h3E] = uw(HALT, 2'd0, 1'b0, 6'h00, 25'h155);
        tick();
        reset = 1'b0;
        tick();
        check("halt_word_upc", 64'(upc), 64'h3E);
        check("halt_word_halted", 64'(halted), 64'h0);
        check("halt_word_ctrl", 64'(ctrl), 64'h155);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halted", 64'(halted), 64'h1);
            check("halted_ctrl", 64'(ctrl), 64'h0);
            check("halted_upc", 64'(upc), 64'h3E);
        end
        check("halted_err", 64'(err), 64'h0);
        reset = 1'b1;
        tick();
        check("unhalt_upc", 64'(upc), 64'h00);
        check("unhalt_halted", 64'(halted), 64'h0);
        check("unhalt_ctrl", 64'(ctrl), 64'h0);
        reset = 1'b0; #1;
        check("unhalt_rel_ctrl", 64'(ctrl), 64'h7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
